micro_sequencer: RTL

- Upstream instruction sequencer for the 4-register ALU stage.
- Holds a small loadable program store of 9-bit control words and steps through it after a start pulse.
- Presents each word on a valid/ready handshake to the ALU's ctrl input.
- Stops on a halt word, on an illegal opcode, or after the last address.

---
 rtl/micro_sequencer_if.sv | 11 +
 rtl/micro_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/micro_sequencer_if.sv
// Control-word handshake between micro_sequencer (master) and the ALU stage (slave).
interface micro_sequencer_if #(
  parameter int CTRL_W = 9
);
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_valid;
  logic              ctrl_ready;

  modport master (output ctrl, output ctrl_valid, input ctrl_ready);
  modport slave  (input ctrl, input ctrl_valid, output ctrl_ready);
endinterface

// File: rtl/micro_sequencer.sv
// Loadable program store stepped by an IDLE/FETCH/DECODE/ISSUE/DONE FSM feeding the ALU ctrl handshake.
// Optional MICRO_SEQ_SINGLE_STEP_EN adds a step input that gates each FETCH.
module micro_sequencer #(
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [CTRL_W-1:0] prog_data,
  input  logic              start,
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  micro_sequencer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issue_count
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, DONE} state_t;
  typedef enum logic [1:0] {OP_LEGAL, OP_HALT, OP_ILLEGAL} op_class_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  function automatic op_class_t classify(input logic [2:0] op);
    case (op)
      3'b101, 3'b010, 3'b111: classify = OP_LEGAL;
      3'b000:                 classify = OP_HALT;
      default:                classify = OP_ILLEGAL;
    endcase
  endfunction

  state_t            state;
  logic [CTRL_W-1:0] mem [2**ADDR_W];
  logic [CTRL_W-1:0] word_p1;
  logic              fetch_go;

`ifdef MICRO_SEQ_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  // Program store: writes locked out during a run, 1-cycle registered read
  always_ff @(posedge clk) begin
    if (prog_we && !busy)
      mem[prog_addr] <= prog_data;
    if (state == FETCH && fetch_go)
      word_p1 <= mem[pc];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.ctrl       <= '0;
      bus.ctrl_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      pc             <= '0;
      issue_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            pc          <= '0;
            issue_count <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
          end
        end
        FETCH: begin
          if (fetch_go)
            state <= DECODE;
        end
        DECODE: begin
          case (classify(word_p1[2:0]))
            OP_LEGAL: begin
              bus.ctrl       <= word_p1;
              bus.ctrl_valid <= 1'b1;
              state          <= ISSUE;
            end
            OP_HALT:  state <= DONE;
            default: begin
              err   <= 1'b1;
              state <= DONE;
            end
          endcase
        end
        ISSUE: begin
          if (bus.ctrl_ready) begin
            bus.ctrl_valid <= 1'b0;
            issue_count    <= issue_count + CNT_ONE;
            // Last address ends the run instead of wrapping to 0
            if (pc == LAST_ADDR) begin
              state <= DONE;
            end else begin
              pc    <= pc + PC_ONE;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
